// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-triggered fixed-priority interrupt controller
// One interrupt in flight at a time: IDLE arbitrates, REQ presents to the core, ACTIVE runs the handler.
module int_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_sig,
  input  logic               intc_we,
  input  logic [31:0]        intc_adr,
  input  logic [31:0]        intc_wdata,
  output logic [31:0]        intc_rdata,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               int_req,
  output logic [2:0]         int_id
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

  state_t             r_state;
  logic [NUM_SRC-1:0] r_sig_d;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_en;
  logic               r_gie;
  logic [2:0]         r_id;
  logic               r_req;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_cand;
  logic [7:0]         w_cand8;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_ackclr;
  logic [2:0]         w_win;
  logic               w_busy;
  logic               w_wr_pend;
  logic               w_wr_en;
  logic               w_wr_ctrl;
  logic               w_unused;

  assign w_rise    = int_sig & ~r_sig_d;
  assign w_cand    = r_pend & r_en;
  assign w_cand8   = 8'(w_cand);
  assign w_busy    = (r_state == S_ACTIVE);
  assign w_wr_pend = intc_we && (intc_adr[3:0] == 4'h0);
  assign w_wr_en   = intc_we && (intc_adr[3:0] == 4'h4);
  assign w_wr_ctrl = intc_we && (intc_adr[3:0] == 4'hC);
  assign w_w1c     = w_wr_pend ? intc_wdata[NUM_SRC-1:0] : '0;
  assign w_ackclr  = (r_state == S_REQ && int_ack) ? (NUM_SRC'(1) << r_id) : '0;
  assign w_unused  = ^{intc_adr[31:4], intc_wdata};

  assign int_req = r_req;
  assign int_id  = r_id;

  // Scan from the top so the lowest set index wins.
  always_comb begin
    w_win = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_cand[i]) w_win = 3'(i);
    end
  end

  always_comb begin
    intc_rdata = '0;
    case (intc_adr[3:0])
      4'h0:    intc_rdata = 32'(r_pend);
      4'h4:    intc_rdata = 32'(r_en);
      4'h8:    intc_rdata = {23'd0, w_busy, 5'd0, (w_busy ? r_id : 3'd0)};
      4'hC:    intc_rdata = {31'd0, r_gie};
      default: intc_rdata = '0;
    endcase
  end

  // A new edge outranks any clear aimed at the same bit in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_d <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_gie   <= 1'b0;
    end else begin
      r_sig_d <= int_sig;
      r_pend  <= (r_pend & ~(w_w1c | w_ackclr)) | w_rise;
      if (w_wr_en)   r_en  <= intc_wdata[NUM_SRC-1:0];
      if (w_wr_ctrl) r_gie <= intc_wdata[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= 3'd0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_gie && (|w_cand)) begin
            r_id    <= w_win;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            r_req   <= 1'b0;
            r_state <= S_ACTIVE;
          end else if (!w_cand8[r_id] || !r_gie) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ACTIVE: begin
          if (int_done) r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - scenario bench for int_ctrl
// Expected request ids are queued with the stimulus and checked when int_req rises.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_sig;
  logic        intc_we;
  logic [31:0] intc_adr;
  logic [31:0] intc_wdata;
  logic [31:0] intc_rdata;
  logic        int_ack;
  logic        int_done;
  logic        int_req;
  logic [2:0]  int_id;

  int          checks = 0;
  int          fails = 0;
  int          exp_q[$];
  logic        prev_req = 1'b0;

  int_ctrl #(.NUM_SRC(8)) dut (
    .clk(clk), .rst(rst), .int_sig(int_sig), .intc_we(intc_we),
    .intc_adr(intc_adr), .intc_wdata(intc_wdata), .intc_rdata(intc_rdata),
    .int_ack(int_ack), .int_done(int_done), .int_req(int_req), .int_id(int_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (int_req && !prev_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_req: int_id=%0d, no request expected", int_id);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int_id !== 3'(e)) begin
          fails++;
          $display("FAIL sb_int_id: got %0d expected %0d", int_id, e);
        end
      end
    end
    prev_req = int_req;
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    intc_adr = {28'd0, a};
    intc_wdata = d;
    intc_we = 1'b1;
    @(negedge clk);
    intc_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    intc_adr = {28'd0, a};
    #1;
    d = intc_rdata;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1;
    @(negedge clk);
    int_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (int_req !== 1'b0 || int_id !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: int_req=%b int_id=%0d expected 0/0", int_req, int_id);
    end
    for (int a = 0; a < 16; a += 4) begin
      bus_read(4'(a), d);
      checks++;
      if (d !== 32'd0) begin
        fails++;
        $display("FAIL reset_reg_%0h: got %h expected 0", a, d);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    bus_write(4'h4, 32'h01);
    bus_write(4'hC, 32'h01);
    int_sig = 8'h01;
    exp_q.push_back(0);
    @(negedge clk);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h01 || int_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_edge1: pend=%h int_req=%b expected 01/0", d, int_req);
    end
    @(negedge clk);
    checks++;
    if (int_req !== 1'b1) begin
      fails++;
      $display("FAIL basic_edge2: int_req=%b expected 1", int_req);
    end
    int_sig = 8'h00;
    pulse_ack();
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0 || int_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_ack_pend: pend=%h int_req=%b expected 0/0", d, int_req);
    end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h100) begin
      fails++;
      $display("FAIL basic_cur_active: got %h expected 100", d);
    end
    pulse_done();
    bus_read(4'h8, d);
    checks++;
    if (d[8] !== 1'b0) begin
      fails++;
      $display("FAIL basic_cur_done: busy=%b expected 0", d[8]);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(4'h4, 32'hFF);
    int_sig = 8'h24;
    exp_q.push_back(2);
    exp_q.push_back(5);
    @(negedge clk);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h24) begin
      fails++;
      $display("FAIL prio_pend: got %h expected 24", d);
    end
    @(negedge clk);
    int_sig = 8'h00;
    pulse_ack();
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h102) begin
      fails++;
      $display("FAIL prio_cur: got %h expected 102", d);
    end
    pulse_done();
    checks++;
    if (int_req !== 1'b0) begin
      fails++;
      $display("FAIL prio_gap: int_req=%b expected 0", int_req);
    end
    @(negedge clk);
    checks++;
    if (int_req !== 1'b1) begin
      fails++;
      $display("FAIL prio_second_req: int_req=%b expected 1", int_req);
    end
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_withdraw();
    logic [31:0] d;
    int_sig = 8'h08;
    exp_q.push_back(3);
    @(negedge clk);
    @(negedge clk);
    int_sig = 8'h00;
    bus_write(4'h0, 32'h08);
    @(negedge clk);
    checks++;
    if (int_req !== 1'b0) begin
      fails++;
      $display("FAIL withdraw_req: int_req=%b expected 0", int_req);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(4'h8, d);
      checks++;
      if (d[8] !== 1'b0 || int_req !== 1'b0) begin
        fails++;
        $display("FAIL withdraw_idle_%0d: busy=%b int_req=%b expected 0/0", i, d[8], int_req);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_set_wins_gie();
    logic [31:0] d;
    bus_write(4'hC, 32'h00);
    int_sig = 8'h10;
    bus_write(4'h0, 32'h10);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h10) begin
      fails++;
      $display("FAIL set_wins_pend: got %h expected 10", d);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (int_req !== 1'b0) begin
        fails++;
        $display("FAIL gie_off_%0d: int_req=%b expected 0", i, int_req);
      end
    end
    exp_q.push_back(4);
    bus_write(4'hC, 32'h01);
    checks++;
    if (int_req !== 1'b0) begin
      fails++;
      $display("FAIL gie_on_early: int_req=%b expected 0", int_req);
    end
    @(negedge clk);
    checks++;
    if (int_req !== 1'b1) begin
      fails++;
      $display("FAIL gie_on_req: int_req=%b expected 1", int_req);
    end
    int_sig = 8'h00;
    pulse_ack();
    pulse_done();
  endtask

  task automatic test_reset_active();
    logic [31:0] d;
    int_sig = 8'h01;
    exp_q.push_back(0);
    @(negedge clk);
    @(negedge clk);
    pulse_ack();
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h100) begin
      fails++;
      $display("FAIL rstact_cur_before: got %h expected 100", d);
    end
    rst = 1'b1;
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h0 || int_req !== 1'b0) begin
      fails++;
      $display("FAIL rstact_async: cur=%h int_req=%b expected 0/0", d, int_req);
    end
    @(negedge clk);
    for (int a = 0; a < 16; a += 4) begin
      bus_read(4'(a), d);
      checks++;
      if (d !== 32'd0) begin
        fails++;
        $display("FAIL rstact_reg_%0h: got %h expected 0", a, d);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h01 || int_req !== 1'b0) begin
      fails++;
      $display("FAIL rstact_release_pend: pend=%h int_req=%b expected 01/0", d, int_req);
    end
    int_sig = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    int_sig = 8'h00;
    intc_we = 1'b0;
    intc_adr = 32'd0;
    intc_wdata = 32'd0;
    int_ack = 1'b0;
    int_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_priority();
    test_withdraw();
    test_set_wins_gie();
    test_reset_active();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d expected requests never seen", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: NUM_SRC, 8, number of interrupt sources (1..8); bits at or above NUM_SRC SHALL read 0 and ignore writes.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: int_sig  input  NUM_SRC  level interrupt lines from peripherals (timer on bit 0).
REQ-005 Port: intc_we  input  1  sys_bus write strobe, one write per asserted cycle.
REQ-006 Port: intc_adr  input  32  sys_bus address; only bits [3:0] decoded.
REQ-007 Port: intc_wdata  input  32  sys_bus write data.
REQ-008 Port: intc_rdata  output  32  sys_bus read data, combinational from intc_adr.
REQ-009 Port: int_ack  input  1  core accepts the presented interrupt (trap entry).
REQ-010 Port: int_done  input  1  core finished handler (mret).
REQ-011 Port: int_req  output  1  interrupt request to core.
REQ-012 Port: int_id  output  3  index of requested source, valid while int_req=1.

Function
REQ-013 Register map on intc_adr[3:0]: 0x0 PEND (W1C), 0x4 EN (RW), 0x8 CUR (RO: [2:0] active id, [8] busy), 0xC CTRL (RW, [0] global enable GIE); others read 0, writes ignored.
REQ-014 Edge detect: sig_d SHALL register int_sig each cycle; PEND[i] set when int_sig[i]=1 and sig_d[i]=0.
REQ-015 PEND[i] SHALL clear on write to 0x0 with intc_wdata[i]=1, or on int_ack accepted for id i.
REQ-016 Simultaneous edge-set and W1C/ack-clear on the same bit: set wins, PEND[i]=1.
REQ-017 Candidate vector = PEND & EN; winner = lowest set index (fixed priority, bit 0 highest).
REQ-018 FSM states: IDLE, REQ, ACTIVE; reset to IDLE.
REQ-019 IDLE: if GIE=1 and candidate nonzero, latch winner into id register, go REQ.
REQ-020 REQ: int_req=1, int_id=latched id; int_ack=1 -> clear PEND[id], go ACTIVE.
REQ-021 REQ withdraw: if int_ack=0 and latched id no longer a candidate or GIE=0, go IDLE with int_req=0 next cycle; no re-arbitration within REQ.
REQ-022 int_ack and withdraw condition in the same cycle: ack wins, go ACTIVE.
REQ-023 ACTIVE: int_req=0, CUR[8]=1, CUR[2:0]=id; int_done=1 -> go IDLE; no nesting.
REQ-024 int_ack outside REQ and int_done outside ACTIVE SHALL be ignored.
REQ-025 Latency: edge sampled at clock k -> PEND set after k; REQ entered at k+1; int_req high from k+1 onward (two edges from input rise).
REQ-026 int_id SHALL hold latched value in ACTIVE and IDLE (only meaningful with int_req=1).
REQ-027 Writes to PEND, EN, CTRL take effect after the write edge; same-cycle write and FSM read use pre-write values.

Reset
REQ-028 While rst=1: PEND, EN, CTRL, sig_d, id = 0; state IDLE; int_req=0; int_id=0; intc_rdata from zeroed registers.
REQ-029 Reset mid-REQ or mid-ACTIVE SHALL drop int_req asynchronously and discard pending state.
REQ-030 int_sig held high across reset release SHALL set PEND (sig_d=0 after reset).

Verification
REQ-031 EN=0x01, GIE=1, pulse int_sig[0] -> int_req=1, int_id=0 two edges after rise; ack -> PEND=0, CUR=0x100; done -> CUR[8]=0.
REQ-032 EN=0xFF, GIE=1, int_sig[5] and int_sig[2] rise same cycle -> int_id=2; after ack/done, int_id=5 requested next.
REQ-033 In REQ for id 3, write PEND=0x08 with no ack -> int_req=0 next cycle, state IDLE, no ACTIVE.
REQ-034 Same cycle: new edge on bit 4 and W1C 0x10 -> PEND[4]=1 afterwards.
REQ-035 GIE=0 with PEND&EN nonzero -> int_req stays 0; set GIE=1 -> int_req=1 next edge+1.
REQ-036 Assert rst during ACTIVE -> int_req=0, CUR=0, all registers read 0; int_sig[0] held high -> PEND=0x01 one edge after release.
